// File: rtl/alu_share_pkg.sv
// Shared constants for the ALU sharing controller: ALU width, op codes and FSM encodings.
// Optional feature macro consumed by users of this package: ALU_SHARE_FIXED_PRIO_EN.
package alu_share_pkg;

  localparam int unsigned W = 16;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or after ptr.
// ALU_SHARE_FIXED_PRIO_EN forces the search to start at index 0 (lowest index wins).
module rr_arbiter
  import alu_share_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned PW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt
);

  logic [PW-1:0] start;

`ifdef ALU_SHARE_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign start      = '0;
`else
  assign start = ptr;
`endif

  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      idx = PW'((int'(start) + k) % int'(N_REQ));
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one external combinational ALU among N_REQ requesters (IDLE -> EXEC -> RESP).
// Define ALU_SHARE_FIXED_PRIO_EN for fixed lowest-index priority instead of round robin.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [2*N_REQ-1:0]   req_op,
  input  logic [W*N_REQ-1:0]   req_a,
  input  logic [W*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [W-1:0]         rsp_data,
  output logic                 rsp_zero,
  output logic [W-1:0]         alu_a,
  output logic [W-1:0]         alu_b,
  output logic [1:0]           alu_op,
  input  logic [W-1:0]         alu_out,
  input  logic                 alu_zero
);

  localparam int unsigned PW = $clog2(N_REQ);

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [W-1:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [W-1:0]     rsp_data_q, rsp_data_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [PW-1:0]    ptr, win_idx;
  logic [N_REQ-1:0] arb_gnt;
  logic [W-1:0]     a_arr [N_REQ];
  logic [W-1:0]     b_arr [N_REQ];
  logic [1:0]       op_arr [N_REQ];

`ifdef ALU_SHARE_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  assign ptr = rr_ptr_q;
`endif

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req(req),
    .ptr(ptr),
    .gnt(arb_gnt)
  );

  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) begin
      a_arr[i]  = req_a[i*W +: W];
      b_arr[i]  = req_b[i*W +: W];
      op_arr[i] = req_op[i*2 +: 2];
    end
  end

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (arb_gnt[i]) win_idx = PW'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    rsp_data_d = rsp_data_q;
    rsp_zero_d = rsp_zero_q;
`ifndef ALU_SHARE_FIXED_PRIO_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          owner_d  = win_idx;
          alu_a_d  = a_arr[win_idx];
          alu_b_d  = b_arr[win_idx];
          alu_op_d = op_arr[win_idx];
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_data_d = alu_out;
        rsp_zero_d = alu_zero;
        state_d    = S_RESP;
      end
      S_RESP: begin
`ifndef ALU_SHARE_FIXED_PRIO_EN
        rr_ptr_d = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
`endif
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      rsp_data_q <= rsp_data_d;
      rsp_zero_q <= rsp_zero_d;
`ifndef ALU_SHARE_FIXED_PRIO_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  // Grant is the accept strobe of the IDLE cycle; suppressed while reset is asserted.
  assign gnt = (state_q == S_IDLE && rst_n) ? arb_gnt : '0;

  always_comb begin
    rsp_valid = '0;
    if (state_q == S_RESP) rsp_valid[owner_q] = 1'b1;
  end

  assign rsp_data = rsp_data_q;
  assign rsp_zero = rsp_zero_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: transaction-level model plus directed literal checks.
module tb_alu_share_ctrl;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [2*N-1:0]  req_op;
  logic [16*N-1:0] req_a, req_b;
  logic [N-1:0]    gnt, rsp_valid;
  logic [15:0]     rsp_data, alu_a, alu_b, alu_out;
  logic            rsp_zero, alu_zero;
  logic [1:0]      alu_op;

  always #5 clk = ~clk;

  alu_share_ctrl #(.N_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out), .alu_zero(alu_zero)
  );

  // ALU behaviour: results mod 2^16, Zero only for SUB with a zero result.
  function automatic logic [16:0] alu_fn(input logic [1:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [15:0] r;
    case (op)
      2'b00:   r = a + b;
      2'b01:   r = a - b;
      2'b10:   r = a + 16'd1;
      default: r = a ^ b;
    endcase
    return {(op == 2'b01) && (r == 16'd0), r};
  endfunction

  assign {alu_zero, alu_out} = alu_fn(alu_op, alu_a, alu_b);

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int start);
    int s;
`ifdef ALU_SHARE_FIXED_PRIO_EN
    s = 0;
`else
    s = start;
`endif
    for (int k = 0; k < N; k++) begin
      if (r[(s + k) % N]) return (s + k) % N;
    end
    return -1;
  endfunction

  // Transaction model: grant at c, response at c+2, next grant no earlier than c+3.
  typedef struct {
    int          due;
    int          owner;
    logic [15:0] data;
    logic        zero;
  } rsp_t;

  rsp_t        q[$];
  rsp_t        ent;
  bit          model_on = 1'b0;
  int          m_ptr = 0, m_free = 0, e_w;
  logic [15:0] m_data, m_a, m_b;
  logic        m_zero;
  logic [1:0]  m_op;
  logic [N-1:0] e_gnt, e_rsp;
  logic [16:0] r17;

  always @(negedge clk) begin
    if (model_on) begin
      if (!rst_n) begin
        check("gnt_in_reset", 32'(gnt), 32'd0);
        check("rsp_valid_in_reset", 32'(rsp_valid), 32'd0);
        q.delete();
        m_ptr = 0; m_free = cyc + 1;
        m_data = '0; m_zero = 1'b0; m_a = '0; m_b = '0; m_op = '0;
      end else begin
        e_gnt = '0; e_w = -1;
        if (cyc >= m_free && req != '0) begin
          e_w = pick(req, m_ptr);
          e_gnt[e_w] = 1'b1;
        end
        e_rsp = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
          e_rsp[q[0].owner] = 1'b1;
          m_data = q[0].data;
          m_zero = q[0].zero;
          m_ptr  = (q[0].owner + 1) % N;
          void'(q.pop_front());
        end
        check("model_gnt", 32'(gnt), 32'(e_gnt));
        check("model_rsp_valid", 32'(rsp_valid), 32'(e_rsp));
        check("model_rsp_data", 32'(rsp_data), 32'(m_data));
        check("model_rsp_zero", 32'(rsp_zero), 32'(m_zero));
        check("model_alu_a", 32'(alu_a), 32'(m_a));
        check("model_alu_b", 32'(alu_b), 32'(m_b));
        check("model_alu_op", 32'(alu_op), 32'(m_op));
        if (e_w >= 0) begin
          m_op = req_op[2*e_w +: 2];
          m_a  = req_a[16*e_w +: 16];
          m_b  = req_b[16*e_w +: 16];
          r17  = alu_fn(m_op, m_a, m_b);
          ent.due = cyc + 2; ent.owner = e_w; ent.data = r17[15:0]; ent.zero = r17[16];
          q.push_back(ent);
          m_free = cyc + 3;
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    check({tag, "_rsp_zero"}, 32'(rsp_zero), 32'd0);
    check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
    check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
    check({tag, "_alu_op"}, 32'(alu_op), 32'd0);
  endtask

  task automatic set_req(input int idx, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b);
    req[idx]            = 1'b1;
    req_op[2*idx +: 2]  = op;
    req_a[16*idx +: 16] = a;
    req_b[16*idx +: 16] = b;
  endtask

  // Bounded wait on gnt[idx] (is_rsp=0) or rsp_valid[idx] (is_rsp=1); t = cycle seen.
  task automatic wait_sig(input bit is_rsp, input int idx, output int t);
    bit ok = 1'b0;
    t = -1;
    for (int k = 0; k < 12 && !ok; k++) begin
      @(negedge clk);
      if (is_rsp ? rsp_valid[idx] : gnt[idx]) begin
        ok = 1'b1;
        t  = cyc;
      end
    end
    check(is_rsp ? "rsp_valid_seen" : "gnt_seen", 32'(ok), 32'd1);
  endtask

  task automatic run_op(input int idx, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_d, input logic exp_z,
                        input bit chg_a, input logic [15:0] new_a);
    int tg, tr;
    @(posedge clk); #1;
    set_req(idx, op, a, b);
    wait_sig(1'b0, idx, tg);
    @(posedge clk); #1;
    req[idx] = 1'b0;
    if (chg_a) req_a[16*idx +: 16] = new_a;
    wait_sig(1'b1, idx, tr);
    check("latency", 32'(tr - tg), 32'd2);
    check("rsp_data_lit", 32'(rsp_data), 32'(exp_d));
    check("rsp_zero_lit", 32'(rsp_zero), 32'(exp_z));
  endtask

  int g_idx[5];
  int g_cyc[5];
  int n_g, t0, t1;

  initial begin
    rst_n = 1'b0; req = '0; req_op = '0; req_a = '0; req_b = '0;
    @(posedge clk); #1;
    model_on = 1'b1;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(0, 2'b00, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 16'h0);
    run_op(2, 2'b01, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 16'h0);
    run_op(2, 2'b11, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 16'h0);
    run_op(1, 2'b10, 16'hFFFF, 16'h5555, 16'h0000, 1'b0, 1'b0, 16'h0);
    run_op(0, 2'b00, 16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b0, 16'h0);
    run_op(1, 2'b01, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 16'h0);
    run_op(3, 2'b01, 16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b1, 16'h0FFF);

    // Reset during EXEC; pointer is 3 beforehand, so a surviving pointer would pick req[3].
    run_op(2, 2'b00, 16'h0100, 16'h0001, 16'h0101, 1'b0, 1'b0, 16'h0);
    @(posedge clk); #1;
    set_req(2, 2'b00, 16'h0200, 16'h0002);
    wait_sig(1'b0, 2, t0);
    @(posedge clk); #1;
    req = '0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_exec_no_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check_zero("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_req(1, 2'b00, 16'h0001, 16'h0002);
    set_req(3, 2'b11, 16'h00F0, 16'h0F00);
    wait_sig(1'b0, 1, t0);
    check("first_after_reset", 32'(gnt), 32'h2);
    @(posedge clk); #1;
    req[1] = 1'b0;
    wait_sig(1'b1, 1, t1);
    check("after_reset_data", 32'(rsp_data), 32'h0003);
    wait_sig(1'b0, 3, t0);
    @(posedge clk); #1;
    req[3] = 1'b0;
    wait_sig(1'b1, 3, t1);
    check("after_reset_xor", 32'(rsp_data), 32'h0FF0);

    // Fairness with all requests held continuously, starting from a fresh pointer.
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 2'b00, 16'(i * 16'h0100), 16'(i + 1));
    n_g = 0;
    for (int k = 0; k < 30 && n_g < 5; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (gnt[i] && n_g < 5) begin
          g_idx[n_g] = i;
          g_cyc[n_g] = cyc;
          n_g++;
        end
      end
    end
    check("fair_grant_count", 32'(n_g), 32'd5);
    @(posedge clk); #1;
    req = '0;
    for (int i = 0; i < 5; i++) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
      check("fair_order", 32'(g_idx[i]), 32'd0);
`else
      check("fair_order", 32'(g_idx[i]), 32'(i % N));
`endif
      if (i > 0) check("fair_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'd3);
    end
    repeat (6) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
